inst_fetch: RTL and testbench

Instruction-fetch front end that consumes the PC register's fetch address and drives the PC register's stall input. It issues one request at a time on the instruction bus using a req/gnt/rvalid handshake, and presents each returned instruction word to decode. It discards responses made stale by a jump and buffers one response while the pipeline is held.

---
 rtl/inst_fetch_pkg.sv | 20 ++
 rtl/inst_fetch.sv | 122 ++++++++++++
 tb/tb_inst_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage constants and the fetch controller state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package inst_fetch_pkg;

    localparam int InstAddrBus   = 32;
    localparam int Hold_Flag_Bus = 3;

    localparam logic [InstAddrBus-1:0]   CpuResetAddr = 32'h0000_0000;
    localparam logic [31:0]              INST_NOP     = 32'h0000_0013;
    localparam logic [Hold_Flag_Bus-1:0] Hold_If      = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch front end: one outstanding req/gnt/rvalid bus access, result registered to decode.
// Latency: 3 cycles per instruction on a zero-wait bus (IDLE, REQ, WAIT); inst_valid_o one cycle after rvalid.
// Backpressure: hold_flag_i >= Hold_If parks a returned word in a one-entry buffer; stall_flag_o freezes the PC.
// Ports: clk/rst (async active-high); pc_i, jump_flag_i, hold_flag_i from the pipeline;
//        req_o/addr_o/gnt_i/rvalid_i/rdata_i to the instruction bus; inst_o/inst_addr_o/inst_valid_o to decode;
//        stall_flag_o back to the PC register (low only in the cycle an instruction is delivered).
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [InstAddrBus-1:0]   pc_i,
    input  logic                     jump_flag_i,
    input  logic [Hold_Flag_Bus-1:0] hold_flag_i,
    output logic                     req_o,
    output logic [InstAddrBus-1:0]   addr_o,
    input  logic                     gnt_i,
    input  logic                     rvalid_i,
    input  logic [31:0]              rdata_i,
    output logic [31:0]              inst_o,
    output logic [InstAddrBus-1:0]   inst_addr_o,
    output logic                     inst_valid_o,
    output logic                     stall_flag_o
);

    fetch_state_t           state;
    logic [InstAddrBus-1:0] addr_q;
    logic                   drop_q;     // next rvalid belongs to a request made stale by a jump
    logic [31:0]            buf_data;
    logic [InstAddrBus-1:0] buf_addr;

    logic hold_if;
    logic deliver_wait;
    logic deliver_hold;

    assign hold_if      = (hold_flag_i >= Hold_If);
    assign deliver_wait = (state == WAIT) && rvalid_i && !drop_q && !jump_flag_i && !hold_if;
    assign deliver_hold = (state == HOLD) && !jump_flag_i && !hold_if;

    // The PC may only advance on the edge that hands an instruction to decode.
    assign stall_flag_o = !(deliver_wait || deliver_hold);
    assign req_o        = (state == REQ);
    assign addr_o       = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= CpuResetAddr;
            drop_q       <= 1'b0;
            buf_data     <= '0;
            buf_addr     <= '0;
            inst_o       <= INST_NOP;
            inst_addr_o  <= CpuResetAddr;
            inst_valid_o <= 1'b0;
        end else begin
            inst_valid_o <= 1'b0;

            // A jump flushes decode and any buffered word regardless of state.
            if (jump_flag_i) begin
                inst_o   <= INST_NOP;
                buf_data <= '0;
                buf_addr <= '0;
            end

            case (state)
                IDLE: begin
                    addr_q <= pc_i;
                    // On a jump pc_i is still the old PC; re-latch the target next cycle.
                    if (!jump_flag_i) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    // The bus address must stay stable until granted, so a jump only
                    // marks the pending response for discard.
                    if (jump_flag_i) begin
                        drop_q <= 1'b1;
                    end
                    if (gnt_i) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (jump_flag_i) begin
                        if (rvalid_i) begin
                            drop_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end else if (rvalid_i) begin
                        if (drop_q) begin
                            drop_q <= 1'b0;
                            state  <= IDLE;
                        end else if (hold_if) begin
                            buf_data <= rdata_i;
                            buf_addr <= addr_q;
                            state    <= HOLD;
                        end else begin
                            inst_o       <= rdata_i;
                            inst_addr_o  <= addr_q;
                            inst_valid_o <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (jump_flag_i) begin
                        state <= IDLE;
                    end else if (!hold_if) begin
                        inst_o       <= buf_data;
                        inst_addr_o  <= buf_addr;
                        inst_valid_o <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: PC register and a memory returning addr+0x100 modelled around the DUT,
// directed scenarios plus a randomized run checked against an architectural fetch-order model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = 32'h0;
    logic        jump_flag_i = 1'b0;
    logic [2:0]  hold_flag_i = 3'd0;
    logic        req_o;
    logic [31:0] addr_o;
    logic        gnt_i = 1'b0;
    logic        rvalid_i = 1'b0;
    logic [31:0] rdata_i = 32'h0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        stall_flag_o;

    logic [31:0] jump_addr = 32'h0;
    int          gnt_wait_cfg = 0;
    int          rvalid_wait_cfg = 0;
    int          total = 0;
    int          bad = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    inst_fetch dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .jump_flag_i(jump_flag_i), .hold_flag_i(hold_flag_i),
        .req_o(req_o), .addr_o(addr_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o),
        .stall_flag_o(stall_flag_o)
    );

    always #5 clk = ~clk;

    // Environment: PC register and a single-outstanding bus responder.
    logic        s_rst = 1'b1, s_stall = 1'b1, s_jump = 1'b0, s_gnt = 1'b0, s_rvalid = 1'b0;
    logic [31:0] s_jaddr = 32'h0, s_addr = 32'h0, raddr = 32'h0;
    logic        req_pend = 1'b0, outst = 1'b0;
    int          gcnt = 0, rcnt = 0;

    initial begin : env
        forever begin
            @(posedge clk);
            #1;
            if (s_rst) begin
                pc_i = 32'h0; req_pend = 1'b0; outst = 1'b0;
            end else begin
                if (s_jump) pc_i = s_jaddr;
                else if (!s_stall) pc_i = pc_i + 32'd4;
                if (s_rvalid) outst = 1'b0;
                if (s_gnt) begin
                    req_pend = 1'b0; outst = 1'b1; raddr = s_addr; rcnt = rvalid_wait_cfg;
                end
            end
            gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'h0;
            if (outst) begin
                if (rcnt == 0) begin rvalid_i = 1'b1; rdata_i = raddr + 32'h100; end
                else rcnt--;
            end
            if (req_o) begin
                if (!req_pend) begin req_pend = 1'b1; gcnt = gnt_wait_cfg; end
                if (gcnt == 0) gnt_i = 1'b1;
                else gcnt--;
            end
            @(negedge clk);
            s_rst = rst; s_stall = stall_flag_o; s_jump = jump_flag_i; s_jaddr = jump_addr;
            s_gnt = gnt_i; s_rvalid = rvalid_i; s_addr = addr_o;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the edge that starts cycle 0 with rst released.
    task automatic do_reset();
        next_cycle();
        rst = 1'b1; jump_flag_i = 1'b0; hold_flag_i = 3'd0;
        gnt_wait_cfg = 0; rvalid_wait_cfg = 0;
        repeat (2) next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", req_o); end
        total++; if (addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", addr_o); end
        total++; if (inst_o !== NOP) begin bad++; $display("FAIL rst_inst got=%h exp=%h", inst_o, NOP); end
        total++; if (inst_addr_o !== 32'h0) begin bad++; $display("FAIL rst_inst_addr got=%h exp=0", inst_addr_o); end
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", inst_valid_o); end
        total++; if (stall_flag_o !== 1'b1) begin bad++; $display("FAIL rst_stall got=%b exp=1", stall_flag_o); end
    endtask

    task automatic test_zero_wait();
        logic exp_req, exp_stall, exp_vld;
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            exp_req   = (c % 3 == 1);
            exp_stall = (c % 3 != 2);
            exp_vld   = (c > 0) && (c % 3 == 0);
            total++; if (req_o !== exp_req) begin bad++; $display("FAIL zw_req c=%0d got=%b exp=%b", c, req_o, exp_req); end
            total++; if (stall_flag_o !== exp_stall) begin bad++; $display("FAIL zw_stall c=%0d got=%b exp=%b", c, stall_flag_o, exp_stall); end
            total++; if (inst_valid_o !== exp_vld) begin bad++; $display("FAIL zw_valid c=%0d got=%b exp=%b", c, inst_valid_o, exp_vld); end
            if (exp_req) begin
                total++; if (addr_o !== 32'((c / 3) * 4)) begin bad++; $display("FAIL zw_addr c=%0d got=%h exp=%h", c, addr_o, 32'((c / 3) * 4)); end
            end
            if (exp_vld) begin
                total++; if (inst_addr_o !== 32'((c / 3 - 1) * 4)) begin bad++; $display("FAIL zw_inst_addr c=%0d got=%h exp=%h", c, inst_addr_o, 32'((c / 3 - 1) * 4)); end
                total++; if (inst_o !== 32'((c / 3 - 1) * 4 + 256)) begin bad++; $display("FAIL zw_inst c=%0d got=%h exp=%h", c, inst_o, 32'((c / 3 - 1) * 4 + 256)); end
            end
        end
    endtask

    task automatic test_gnt_delay();
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            if (c == 5) gnt_wait_cfg = 3;
            if (c >= 7 && c <= 10) begin
                total++; if (req_o !== 1'b1) begin bad++; $display("FAIL gd_req c=%0d got=%b exp=1", c, req_o); end
                total++; if (addr_o !== 32'h8) begin bad++; $display("FAIL gd_addr c=%0d got=%h exp=8", c, addr_o); end
                total++; if (stall_flag_o !== 1'b1) begin bad++; $display("FAIL gd_stall c=%0d got=%b exp=1", c, stall_flag_o); end
            end
            if (c == 11) begin
                total++; if (req_o !== 1'b0) begin bad++; $display("FAIL gd_req_off got=%b exp=0", req_o); end
                total++; if (stall_flag_o !== 1'b0) begin bad++; $display("FAIL gd_deliver_stall got=%b exp=0", stall_flag_o); end
            end
            if (c == 12) begin
                total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h8 || inst_o !== 32'h108) begin
                    bad++; $display("FAIL gd_out got=%b/%h/%h exp=1/8/108", inst_valid_o, inst_addr_o, inst_o); end
            end
        end
        gnt_wait_cfg = 0;
    endtask

    task automatic test_jump_wait();
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) next_cycle();
            if (c == 5) begin jump_flag_i = 1'b1; jump_addr = 32'h40; end
            if (c == 6) jump_flag_i = 1'b0;
            @(negedge clk);
            if (c == 3) rvalid_wait_cfg = 2;
            if (c == 5) begin
                rvalid_wait_cfg = 0;
                total++; if (stall_flag_o !== 1'b1) begin bad++; $display("FAIL jw_stall got=%b exp=1", stall_flag_o); end
            end
            if (c == 6) begin
                total++; if (inst_o !== NOP || inst_valid_o !== 1'b0) begin
                    bad++; $display("FAIL jw_nop got=%h/%b exp=%h/0", inst_o, inst_valid_o, NOP); end
            end
            if (c == 7) begin
                total++; if (rvalid_i !== 1'b1 || stall_flag_o !== 1'b1) begin
                    bad++; $display("FAIL jw_discard rvalid=%b stall=%b exp=1/1", rvalid_i, stall_flag_o); end
            end
            if (c == 8) begin
                total++; if (inst_valid_o !== 1'b0 || req_o !== 1'b0) begin
                    bad++; $display("FAIL jw_no_out valid=%b req=%b exp=0/0", inst_valid_o, req_o); end
            end
            if (c == 9) begin
                total++; if (req_o !== 1'b1 || addr_o !== 32'h40) begin
                    bad++; $display("FAIL jw_new_req got=%b/%h exp=1/40", req_o, addr_o); end
            end
            if (c == 11) begin
                total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h40 || inst_o !== 32'h140) begin
                    bad++; $display("FAIL jw_out got=%b/%h/%h exp=1/40/140", inst_valid_o, inst_addr_o, inst_o); end
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            if (c > 0) next_cycle();
            if (c == 8) hold_flag_i = 3'd3;
            if (c == 13) hold_flag_i = 3'd0;
            @(negedge clk);
            if (c == 8) begin
                total++; if (rvalid_i !== 1'b1 || stall_flag_o !== 1'b1) begin
                    bad++; $display("FAIL hd_stall_rv rvalid=%b stall=%b exp=1/1", rvalid_i, stall_flag_o); end
            end
            if (c >= 9 && c <= 12) begin
                total++; if (stall_flag_o !== 1'b1 || inst_valid_o !== 1'b0 || inst_addr_o !== 32'h4 || inst_o !== 32'h104) begin
                    bad++; $display("FAIL hd_frozen c=%0d got=%b/%b/%h/%h exp=1/0/4/104", c, stall_flag_o, inst_valid_o, inst_addr_o, inst_o); end
            end
            if (c == 13) begin
                total++; if (stall_flag_o !== 1'b0) begin bad++; $display("FAIL hd_release_stall got=%b exp=0", stall_flag_o); end
            end
            if (c == 14) begin
                total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h8 || inst_o !== 32'h108 || req_o !== 1'b0) begin
                    bad++; $display("FAIL hd_out got=%b/%h/%h req=%b exp=1/8/108 req=0", inst_valid_o, inst_addr_o, inst_o, req_o); end
            end
            if (c == 15) begin
                total++; if (req_o !== 1'b1 || addr_o !== 32'hC || inst_valid_o !== 1'b0) begin
                    bad++; $display("FAIL hd_next got=%b/%h valid=%b exp=1/c valid=0", req_o, addr_o, inst_valid_o); end
            end
        end
    endtask

    task automatic test_jump_rvalid();
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) next_cycle();
            if (c == 5) begin jump_flag_i = 1'b1; jump_addr = 32'h80; end
            if (c == 6) jump_flag_i = 1'b0;
            @(negedge clk);
            if (c == 5) begin
                total++; if (rvalid_i !== 1'b1 || stall_flag_o !== 1'b1) begin
                    bad++; $display("FAIL jr_stall rvalid=%b stall=%b exp=1/1", rvalid_i, stall_flag_o); end
            end
            if (c == 6) begin
                total++; if (inst_o !== NOP || inst_valid_o !== 1'b0 || req_o !== 1'b0) begin
                    bad++; $display("FAIL jr_nop got=%h/%b req=%b exp=%h/0 req=0", inst_o, inst_valid_o, req_o, NOP); end
            end
            if (c == 7) begin
                total++; if (req_o !== 1'b1 || addr_o !== 32'h80) begin
                    bad++; $display("FAIL jr_new_req got=%b/%h exp=1/80", req_o, addr_o); end
            end
            if (c == 9) begin
                total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h80 || inst_o !== 32'h180) begin
                    bad++; $display("FAIL jr_out got=%b/%h/%h exp=1/80/180", inst_valid_o, inst_addr_o, inst_o); end
            end
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            if (c > 0) next_cycle();
            if (c == 9) rst = 1'b1;
            if (c == 11) rst = 1'b0;
            @(negedge clk);
            if (c == 6) rvalid_wait_cfg = 3;
            if (c == 9) begin
                rvalid_wait_cfg = 0;
                total++; if (req_o !== 1'b0 || addr_o !== 32'h0 || stall_flag_o !== 1'b1) begin
                    bad++; $display("FAIL rm_bus got req=%b addr=%h stall=%b exp=0/0/1", req_o, addr_o, stall_flag_o); end
                total++; if (inst_o !== NOP || inst_addr_o !== 32'h0 || inst_valid_o !== 1'b0) begin
                    bad++; $display("FAIL rm_out got=%h/%h/%b exp=%h/0/0", inst_o, inst_addr_o, inst_valid_o, NOP); end
            end
            if (c == 12) begin
                total++; if (req_o !== 1'b1 || addr_o !== 32'h0) begin
                    bad++; $display("FAIL rm_restart got=%b/%h exp=1/0", req_o, addr_o); end
            end
            if (c == 14) begin
                total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== 32'h100) begin
                    bad++; $display("FAIL rm_out2 got=%b/%h/%h exp=1/0/100", inst_valid_o, inst_addr_o, inst_o); end
            end
        end
    endtask

    // Architectural model: decode must see the program-order address stream, where each
    // delivered instruction advances the expected address by 4 and a jump redirects it.
    task automatic test_random();
        logic [31:0] exp_next, prev_inst, prev_iaddr, prev_addr;
        logic        prev_jump, prev_frz, prev_req, prev_gnt;
        int          hold_run, deliveries;
        exp_next = 32'h0; hold_run = 0; deliveries = 0;
        prev_jump = 1'b0; prev_frz = 1'b0; prev_req = 1'b0; prev_gnt = 1'b0;
        prev_inst = 32'h0; prev_iaddr = 32'h0; prev_addr = 32'h0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c > 0) next_cycle();
            if (hold_run > 0) begin
                hold_flag_i = 3'($urandom_range(2, 7)); hold_run--;
            end else begin
                hold_flag_i = 3'($urandom_range(0, 1));
                if ($urandom_range(0, 19) == 0) hold_run = int'($urandom_range(1, 6));
            end
            jump_flag_i = ($urandom_range(0, 15) == 0);
            jump_addr   = {16'h0, 14'($urandom), 2'b00};
            @(negedge clk);
            gnt_wait_cfg    = int'($urandom_range(0, 3));
            rvalid_wait_cfg = int'($urandom_range(0, 3));
            if (c > 0) begin
                if (prev_jump) begin
                    total++; if (inst_o !== NOP || inst_valid_o !== 1'b0) begin
                        bad++; $display("FAIL rnd_flush c=%0d got=%h/%b exp=%h/0", c, inst_o, inst_valid_o, NOP); end
                end else if (prev_frz) begin
                    total++; if (inst_valid_o !== 1'b0 || inst_o !== prev_inst || inst_addr_o !== prev_iaddr) begin
                        bad++; $display("FAIL rnd_freeze c=%0d got=%b/%h/%h exp=0/%h/%h", c, inst_valid_o, inst_o, inst_addr_o, prev_inst, prev_iaddr); end
                end
                if (prev_req && !prev_gnt && req_o) begin
                    total++; if (addr_o !== prev_addr) begin
                        bad++; $display("FAIL rnd_addr_stable c=%0d got=%h exp=%h", c, addr_o, prev_addr); end
                end
            end
            if (jump_flag_i || hold_flag_i >= 3'd2) begin
                total++; if (stall_flag_o !== 1'b1) begin
                    bad++; $display("FAIL rnd_stall c=%0d got=%b exp=1", c, stall_flag_o); end
            end
            if (inst_valid_o === 1'b1) begin
                total++; if (inst_addr_o !== exp_next) begin
                    bad++; $display("FAIL rnd_order c=%0d got=%h exp=%h", c, inst_addr_o, exp_next); end
                total++; if (inst_o !== inst_addr_o + 32'h100) begin
                    bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, inst_o, inst_addr_o + 32'h100); end
                exp_next = inst_addr_o + 32'd4;
                deliveries++;
            end
            if (jump_flag_i) exp_next = jump_addr;
            prev_jump = jump_flag_i; prev_frz = (hold_flag_i >= 3'd2);
            prev_inst = inst_o; prev_iaddr = inst_addr_o;
            prev_req = req_o; prev_gnt = gnt_i; prev_addr = addr_o;
        end
        jump_flag_i = 1'b0; hold_flag_i = 3'd0;
        total++; if (deliveries < 100) begin
            bad++; $display("FAIL rnd_progress got=%0d exp>=100", deliveries); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_gnt_delay();
        test_jump_wait();
        test_hold();
        test_jump_rvalid();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
